// File: rtl/aes_byte_scanner_if.sv
// Handshake/data bundle between an AES result source and the byte scanner.
// master drives load/data_in; slave returns scan status and BCD digits.
interface aes_byte_scanner_if;
    logic         load;
    logic [0:127] data_in;
    logic         busy;
    logic [3:0]   byte_idx;
    logic [3:0]   hunds;
    logic [3:0]   tens;
    logic [3:0]   units;
    logic         digits_valid;
    logic         done;

    modport master (
        output load, data_in,
        input  busy, byte_idx, hunds, tens, units, digits_valid, done
    );

    modport slave (
        input  load, data_in,
        output busy, byte_idx, hunds, tens, units, digits_valid, done
    );
endinterface

// File: rtl/aes_byte_scanner.sv
// Scans the 16 bytes of a captured AES state through a sequential double-dabble
// and holds each BCD result for HOLD_CYCLES. Optional macro: AES_SCAN_LOOP_EN.
module aes_byte_scanner #(
    parameter logic [31:0] HOLD_CYCLES = 32'd25000000
) (
    input  logic              clk,
    input  logic              reset,
    aes_byte_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t       state_q, state_d;
    logic [0:127] data_q, data_d;
    logic [19:0]  sr_q, sr_d;
    logic [2:0]   step_q, step_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   hunds_q, hunds_d;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   units_q, units_d;
    logic         dv_q, dv_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic [19:0]  sr_adj;
    logic [19:0]  sr_sh;
    logic [3:0]   idx_nx;
    logic [7:0]   byte_nx;
    logic         hold_end;

    always_comb begin
        sr_adj = sr_q;
        if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
        if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
        if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
        sr_sh    = sr_adj << 1;
        // idx_nx wraps 15->0, which is exactly the loop-mode restart byte
        idx_nx   = idx_q + 4'd1;
        byte_nx  = data_q[8*idx_nx +: 8];
        hold_end = (cnt_q == HOLD_CYCLES - 32'd1);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sr_d    = sr_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hunds_d = hunds_q;
        tens_d  = tens_q;
        units_d = units_q;
        dv_d    = dv_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    data_d  = bus.data_in;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    sr_d    = {12'd0, bus.data_in[0:7]};
                    step_d  = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d   = sr_sh;
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    hunds_d = sr_sh[19:16];
                    tens_d  = sr_sh[15:12];
                    units_d = sr_sh[11:8];
                    dv_d    = 1'b1;
                    cnt_d   = 32'd0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_end) begin
                    dv_d = 1'b0;
`ifdef AES_SCAN_LOOP_EN
                    done_d  = (idx_q == 4'd15);
                    idx_d   = idx_nx;
                    sr_d    = {12'd0, byte_nx};
                    step_d  = 3'd0;
                    state_d = CONV;
`else
                    if (idx_q != 4'd15) begin
                        idx_d   = idx_nx;
                        sr_d    = {12'd0, byte_nx};
                        step_d  = 3'd0;
                        state_d = CONV;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AES_SCAN_LOOP_EN
        // A new load preempts the running scan, including a coincident wrap
        if (bus.load && busy_q) begin
            data_d  = bus.data_in;
            idx_d   = 4'd0;
            sr_d    = {12'd0, bus.data_in[0:7]};
            step_d  = 3'd0;
            dv_d    = 1'b0;
            done_d  = 1'b0;
            state_d = CONV;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            sr_q    <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            hunds_q <= '0;
            tens_q  <= '0;
            units_q <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sr_q    <= sr_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hunds_q <= hunds_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.byte_idx     = idx_q;
    assign bus.hunds        = hunds_q;
    assign bus.tens         = tens_q;
    assign bus.units        = units_q;
    assign bus.digits_valid = dv_q;
    assign bus.done         = done_q;
endmodule
